// File: rtl/mvt_pkg.sv
// ============================================================================
// Module  : mvt_pkg
// Brief   : Shared defaults, FSM state type and operand generators for MVT.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mvt_pkg;

    localparam int N_DEF      = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALC1 = 3'd1,
        S_WR1   = 3'd2,
        S_CALC2 = 3'd3,
        S_WR2   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    function automatic int unsigned a_elem(input int unsigned i,
                                           input int unsigned j,
                                           input int unsigned n = N_DEF);
        return i * n + j;
    endfunction

    function automatic int unsigned y1_elem(input int unsigned j);
        return j + 1;
    endfunction

    function automatic int unsigned y2_elem(input int unsigned j,
                                            input int unsigned n = N_DEF);
        return n - j;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mvt_wrapper_nibble_serializer.sv
// ============================================================================
// Module  : nibble_serializer
// Brief   : Shifts a loaded word out LSB nibble first, one nibble per cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module nibble_serializer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] word,
    output logic              busy,
    output logic [3:0]        data_out,
    output logic              data_valid
);

    localparam int NIB = DATA_W / 4;
    localparam int CW  = $clog2(NIB + 1);

    logic [DATA_W-1:0] r_shift;
    logic [CW-1:0]     r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (load) begin
            r_shift <= word;
            r_cnt   <= CW'(NIB);
        end else if (r_cnt != '0) begin
            r_shift <= r_shift >> 4;
            r_cnt   <= r_cnt - 1'b1;
        end
    end

    // r_cnt counts nibbles still to present, so it is nonzero exactly while output is valid.
    assign data_valid = (r_cnt != '0);
    assign busy       = data_valid;
    assign data_out   = data_valid ? r_shift[3:0] : 4'h0;

endmodule

`default_nettype wire

// File: rtl/mvt_wrapper.sv
// ============================================================================
// Module  : mvt_wrapper
// Brief   : On-chip MVT benchmark: x1 = A*y1, x2 = A^T*y2, streamed as nibbles.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mvt_wrapper
    import mvt_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic       clk_p,
    input  logic       clk_n,
    input  logic       ap_rst,
    output logic       probe_out,
    output logic [3:0] data_out,
    output logic       data_valid
);

    localparam int IW  = (N > 1) ? $clog2(N) : 1;
    localparam int NIB = DATA_W / 4;
    localparam int CW  = $clog2(NIB + 1);

    logic ap_clk;
    logic w_unused_clk_n;

    assign ap_clk         = clk_p;
    assign w_unused_clk_n = clk_n;

    state_t            r_state;
    state_t            w_next;
    logic [IW-1:0]     r_i;
    logic [IW-1:0]     r_j;
    logic [DATA_W-1:0] r_acc;
    logic [CW-1:0]     r_tail;
    logic              r_probe;

    logic              x1_out_write;
    logic [DATA_W-1:0] x1_out_din;
    logic              x2_out_write;
    logic [DATA_W-1:0] x2_out_din;

    logic              w_busy;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_y;
    logic [DATA_W-1:0] w_prod;
    logic              w_last_j;
    logic              w_last_i;

    assign w_last_j = (r_j == IW'(N - 1));
    assign w_last_i = (r_i == IW'(N - 1));

    always_comb begin
        w_a = '0;
        w_y = '0;
        if (r_state == S_CALC2) begin
            w_a = DATA_W'(a_elem(32'(r_j), 32'(r_i), N));
            w_y = DATA_W'(y2_elem(32'(r_j), N));
        end else begin
            w_a = DATA_W'(a_elem(32'(r_i), 32'(r_j), N));
            w_y = DATA_W'(y1_elem(32'(r_j)));
        end
    end

    assign w_prod = w_a * w_y;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = S_CALC1;
            S_CALC1: if (w_last_j) w_next = S_WR1;
            S_WR1:   if (!w_busy) w_next = w_last_i ? S_CALC2 : S_CALC1;
            S_CALC2: if (w_last_j) w_next = S_WR2;
            S_WR2:   if (!w_busy) w_next = w_last_i ? S_DONE : S_CALC2;
            S_DONE:  w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    assign x1_out_write = (r_state == S_WR1) && !w_busy;
    assign x2_out_write = (r_state == S_WR2) && !w_busy;
    assign x1_out_din   = r_acc;
    assign x2_out_din   = r_acc;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_i     <= '0;
            r_j     <= '0;
            r_acc   <= '0;
            r_tail  <= '0;
            r_probe <= 1'b0;
        end else begin
            case (r_state)
                S_CALC1, S_CALC2: begin
                    r_acc <= r_acc + w_prod;
                    r_j   <= w_last_j ? '0 : r_j + 1'b1;
                end
                S_WR1, S_WR2: begin
                    if (!w_busy) begin
                        r_acc <= '0;
                        r_i   <= w_last_i ? '0 : r_i + 1'b1;
                    end
                end
                S_DONE: begin
                    // Count the final word's nibbles so the flag rises right after the last one.
                    if (w_busy && !r_probe) begin
                        r_tail <= r_tail + 1'b1;
                        if (r_tail == CW'(NIB - 1)) begin
                            r_probe <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_acc <= '0;
                end
            endcase
        end
    end

    assign probe_out = r_probe;

    nibble_serializer #(
        .DATA_W (DATA_W)
    ) u_ser (
        .clk        (ap_clk),
        .rst        (ap_rst),
        .load       (x1_out_write | x2_out_write),
        .word       (x1_out_write ? x1_out_din : x2_out_din),
        .busy       (w_busy),
        .data_out   (data_out),
        .data_valid (data_valid)
    );

endmodule

`default_nettype wire

// File: tb/tb_mvt_wrapper.sv
// ============================================================================
// Module  : tb_mvt_wrapper
// Brief   : Self-checking bench for mvt_wrapper against a timeline/arith model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mvt_wrapper;

    localparam int N   = 8;
    localparam int DW  = 32;
    localparam int NIB = DW / 4;
    localparam int PER = N + 1;

    logic       clk_p  = 1'b0;
    logic       clk_n  = 1'b1;
    logic       ap_rst = 1'b0;
    logic       probe_out;
    logic [3:0] data_out;
    logic       data_valid;

    int checks   = 0;
    int failures = 0;
    int k        = 0;

    mvt_wrapper dut (
        .clk_p      (clk_p),
        .clk_n      (clk_n),
        .ap_rst     (ap_rst),
        .probe_out  (probe_out),
        .data_out   (data_out),
        .data_valid (data_valid)
    );

    always #5 begin
        clk_p = ~clk_p;
        clk_n = ~clk_n;
    end

    // Sample index k = cycle following rising edge Ek.
    function automatic int wcyc(input int w);
        return PER * (w + 1);
    endfunction

    function automatic logic [DW-1:0] exp_word(input int w);
        logic [DW-1:0] s = '0;
        for (int j = 0; j < N; j++) begin
            if (w < N) s += DW'((w * N + j) * (j + 1));
            else       s += DW'((j * N + (w - N)) * (N - j));
        end
        return s;
    endfunction

    function automatic int wr_idx(input int kk);
        for (int w = 0; w < 2 * N; w++) if (wcyc(w) == kk) return w;
        return -1;
    endfunction

    function automatic logic exp_dv(input int kk);
        for (int w = 0; w < 2 * N; w++)
            if (kk > wcyc(w) && kk <= wcyc(w) + NIB) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_nib(input int kk);
        logic [DW-1:0] v;
        for (int w = 0; w < 2 * N; w++) begin
            if (kk > wcyc(w) && kk <= wcyc(w) + NIB) begin
                v = exp_word(w) >> (4 * (kk - wcyc(w) - 1));
                return v[3:0];
            end
        end
        return 4'h0;
    endfunction

    task automatic test_reset();
        int hold;
        logic [70:0] obs;
        hold = $urandom_range(10, 15);
        #1 ap_rst = 1'b1;
        repeat (hold) begin
            @(negedge clk_p);
            obs = {probe_out, data_valid, data_out, dut.x1_out_write, dut.x2_out_write,
                   dut.x1_out_din, dut.x2_out_din};
            checks++;
            if (obs !== '0)
                $display("FAIL reset_outputs: got %h expected 0", obs);
            if (obs !== '0) failures++;
        end
        ap_rst = 1'b0;
        k = 0;
    endtask

    task automatic test_x1();
        int w;
        while (k < wcyc(N - 1)) begin
            @(negedge clk_p);
            k++;
            w = wr_idx(k);
            checks++;
            if (dut.x1_out_write !== (w >= 0 && w < N)) begin
                failures++;
                $display("FAIL x1_write k=%0d: got %b expected %b", k, dut.x1_out_write, (w >= 0));
            end
            if (w >= 0) begin
                checks++;
                if (dut.x1_out_din !== exp_word(w)) begin
                    failures++;
                    $display("FAIL x1_din[%0d]: got %h expected %h", w, dut.x1_out_din, exp_word(w));
                end
                if (w == 0 || w == N - 1) begin
                    checks++;
                    if (dut.x1_out_din !== ((w == 0) ? 32'h0000_00a8 : 32'h0000_0888)) begin
                        failures++;
                        $display("FAIL x1_edge[%0d]: got %h", w, dut.x1_out_din);
                    end
                end
            end
            checks++;
            if (dut.x2_out_write !== 1'b0) begin
                failures++;
                $display("FAIL x2_early k=%0d: got %b expected 0", k, dut.x2_out_write);
            end
            checks++;
            if (data_valid !== exp_dv(k)) begin
                failures++;
                $display("FAIL x1_valid k=%0d: got %b expected %b", k, data_valid, exp_dv(k));
            end
            if (exp_dv(k)) begin
                checks++;
                if (data_out !== exp_nib(k)) begin
                    failures++;
                    $display("FAIL x1_nibble k=%0d: got %h expected %h", k, data_out, exp_nib(k));
                end
            end
        end
    endtask

    task automatic test_x2();
        int w;
        while (k < wcyc(2 * N - 1) + NIB) begin
            @(negedge clk_p);
            k++;
            w = wr_idx(k);
            checks++;
            if (dut.x2_out_write !== (w >= N)) begin
                failures++;
                $display("FAIL x2_write k=%0d: got %b expected %b", k, dut.x2_out_write, (w >= N));
            end
            if (w >= N) begin
                checks++;
                if (dut.x2_out_din !== exp_word(w)) begin
                    failures++;
                    $display("FAIL x2_din[%0d]: got %h expected %h", w - N, dut.x2_out_din, exp_word(w));
                end
                if (w == N || w == 2 * N - 1) begin
                    checks++;
                    if (dut.x2_out_din !== ((w == N) ? 32'h0000_02a0 : 32'h0000_039c)) begin
                        failures++;
                        $display("FAIL x2_edge[%0d]: got %h", w - N, dut.x2_out_din);
                    end
                end
            end
            checks++;
            if (dut.x1_out_write !== 1'b0 || probe_out !== 1'b0) begin
                failures++;
                $display("FAIL x2_phase k=%0d: x1_write=%b probe=%b expected 0 0", k, dut.x1_out_write, probe_out);
            end
            checks++;
            if (data_valid !== exp_dv(k)) begin
                failures++;
                $display("FAIL x2_valid k=%0d: got %b expected %b", k, data_valid, exp_dv(k));
            end
            if (exp_dv(k)) begin
                checks++;
                if (data_out !== exp_nib(k)) begin
                    failures++;
                    $display("FAIL x2_nibble k=%0d: got %h expected %h", k, data_out, exp_nib(k));
                end
            end
        end
    endtask

    task automatic test_completion();
        repeat (20) begin
            @(negedge clk_p);
            k++;
            checks++;
            if (probe_out !== 1'b1 || data_valid !== 1'b0 ||
                dut.x1_out_write !== 1'b0 || dut.x2_out_write !== 1'b0) begin
                failures++;
                $display("FAIL completion k=%0d: probe=%b valid=%b w1=%b w2=%b expected 1 0 0 0",
                         k, probe_out, data_valid, dut.x1_out_write, dut.x2_out_write);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int target;
        int hold;
        #1 ap_rst = 1'b1;
        repeat (2) @(negedge clk_p);
        ap_rst = 1'b0;
        k = 0;
        target = wcyc(N + 3) + $urandom_range(1, NIB);
        while (k < target) begin
            @(negedge clk_p);
            k++;
        end
        checks++;
        if (data_valid !== 1'b1) begin
            failures++;
            $display("FAIL midrun_busy: valid got %b expected 1", data_valid);
        end
        #1 ap_rst = 1'b1;
        #1;
        checks++;
        if ({probe_out, data_valid, data_out, dut.x1_out_write, dut.x2_out_write} !== 8'h00) begin
            failures++;
            $display("FAIL midrun_clear: probe=%b valid=%b data=%h expected all 0",
                     probe_out, data_valid, data_out);
        end
        hold = $urandom_range(2, 6);
        repeat (hold) @(negedge clk_p);
        ap_rst = 1'b0;
        k = 0;
        while (k < PER) begin
            @(negedge clk_p);
            k++;
            if (k < PER) begin
                checks++;
                if (dut.x1_out_write !== 1'b0 || data_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL restart_quiet k=%0d: w1=%b valid=%b expected 0 0",
                             k, dut.x1_out_write, data_valid);
                end
            end
        end
        checks++;
        if (dut.x1_out_write !== 1'b1 || dut.x1_out_din !== 32'h0000_00a8) begin
            failures++;
            $display("FAIL restart_first: write=%b din=%h expected 1 000000a8",
                     dut.x1_out_write, dut.x1_out_din);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_x1();
        test_x2();
        test_completion();
        test_reset_midrun();
        test_x1();
        test_x2();
        test_completion();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
